// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I-subset core: sequences one instruction
// through a shared ALU and memory port, with a memory stall timeout and an illegal-op trap.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Retire,
    output logic       Illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam bit         TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_TRAP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_dec_state;
    logic [7:0] r_cnt;
    logic       r_illegal;

    logic       w_wait_state;
    logic       w_waiting;
    logic       w_timeout;
    logic [2:0] w_funct_alu;

    logic       w_memreq;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_regwrite;
    logic       w_retire;

    // Only the three memory-handshake states can stall.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                          (r_state == S_MEMWRITE);
    assign w_waiting    = w_wait_state && !mem_ready;
    // Trap on the wait cycle that would take the counter to MEM_TIMEOUT.
    assign w_timeout    = TIMEOUT_EN && w_waiting &&
                          (({1'b0, r_cnt} + 9'd1) == TIMEOUT_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (mem_ready || (w_next != r_state)) begin
                r_cnt <= '0;
            end else if (w_waiting) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
            S_ALUWB, S_BEQ:          w_next = S_FETCH;
            S_TRAP:                  w_next = S_TRAP;
            default:                 w_next = S_FETCH;
        endcase
        if (w_timeout) begin
            w_next = S_TRAP;
        end
    end

    // sub is only an R-type encoding; addi with bit 30 set stays add.
    always_comb begin
        w_funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  w_funct_alu = (op[5] && funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            default: w_funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // While in reset the selects show the FETCH decode; enables are gated below.
    assign w_dec_state = rst_n ? r_state : S_FETCH;

    always_comb begin
        w_memreq   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_retire   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        case (w_dec_state)
            S_FETCH: begin
                w_memreq  = 1'b1;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                w_memreq = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEM;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWRITE: begin
                w_memreq   = 1'b1;
                w_memwrite = 1'b1;
                AdrSrc     = 1'b1;
                w_retire   = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = w_funct_alu;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = w_funct_alu;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                w_pcwrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = ALU_SUB;
                w_pcwrite  = Zero;
                w_retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign MemReq   = rst_n && w_memreq;
    assign MemWrite = rst_n && w_memwrite;
    assign IRWrite  = rst_n && w_irwrite;
    assign PCWrite  = rst_n && w_pcwrite;
    assign RegWrite = rst_n && w_regwrite;
    assign Retire   = rst_n && w_retire;
    assign Illegal  = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected per-cycle
// output sequence and latency, driven with directed and random waits.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                   P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_JAL = 9,
                   P_BEQ = 10, P_TRAP = 11, P_RESET = 12;

    // Packed output vector bit positions
    localparam int B_MEMREQ = 18, B_MEMWRITE = 17, B_IRWRITE = 16, B_PCWRITE = 15,
                   B_REGWRITE = 14, B_RETIRE = 13, B_ILLEGAL = 12, B_ADR = 11;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       mem_ready;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Retire, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    int checks = 0;
    int errors = 0;
    int cyc_in_instr;
    int ret_cnt;
    int ret_at;
    int instr_no = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Retire(Retire), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            SW:      return 2'b01;
            BEQ:     return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
        case (f3)
            3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic string pname(input int ph);
        case (ph)
            P_FETCH: return "FETCH";     P_DECODE: return "DECODE";
            P_MEMADR: return "MEMADR";   P_MEMREAD: return "MEMREAD";
            P_MEMWB: return "MEMWB";     P_MEMWRITE: return "MEMWRITE";
            P_EXECR: return "EXECR";     P_EXECI: return "EXECI";
            P_ALUWB: return "ALUWB";     P_JAL: return "JAL";
            P_BEQ: return "BEQ";         P_TRAP: return "TRAP";
            default: return "RESET";
        endcase
    endfunction

    // Expected {value, care-mask} for one cycle of a given instruction phase
    function automatic logic [37:0] expect_of(input int ph, input bit mr, input bit z);
        logic [18:0] v;
        logic [18:0] m;
        v = '0;
        m = 19'h7F018;
        v[4:3] = imm_of(op);
        case (ph)
            P_FETCH, P_RESET: begin
                v[B_MEMREQ]  = (ph == P_FETCH);
                v[B_IRWRITE] = (ph == P_FETCH) && mr;
                v[B_PCWRITE] = (ph == P_FETCH) && mr;
                v[10:9] = 2'b00; v[8:7] = 2'b10; v[6:5] = 2'b10; v[2:0] = 3'b000;
                m |= 19'h00FE7;
                if (ph == P_RESET) m[B_ILLEGAL] = 1'b0;
            end
            P_DECODE: begin
                v[10:9] = 2'b01; v[8:7] = 2'b01; v[2:0] = 3'b000; m |= 19'h00787;
            end
            P_MEMADR: begin
                v[10:9] = 2'b10; v[8:7] = 2'b01; v[2:0] = 3'b000; m |= 19'h00787;
            end
            P_MEMREAD: begin
                v[B_MEMREQ] = 1'b1; v[B_ADR] = 1'b1; v[6:5] = 2'b00; m |= 19'h00860;
            end
            P_MEMWB: begin
                v[B_REGWRITE] = 1'b1; v[B_RETIRE] = 1'b1; v[6:5] = 2'b01; m |= 19'h00060;
            end
            P_MEMWRITE: begin
                v[B_MEMREQ] = 1'b1; v[B_MEMWRITE] = 1'b1; v[B_ADR] = 1'b1;
                v[B_RETIRE] = mr; v[6:5] = 2'b00; m |= 19'h00860;
            end
            P_EXECR: begin
                v[10:9] = 2'b10; v[8:7] = 2'b00; v[2:0] = alu_of(op, funct3, funct7);
                m |= 19'h00787;
            end
            P_EXECI: begin
                v[10:9] = 2'b10; v[8:7] = 2'b01; v[2:0] = alu_of(op, funct3, funct7);
                m |= 19'h00787;
            end
            P_ALUWB: begin
                v[B_REGWRITE] = 1'b1; v[B_RETIRE] = 1'b1; v[6:5] = 2'b00; m |= 19'h00060;
            end
            P_JAL: begin
                v[B_PCWRITE] = 1'b1; v[10:9] = 2'b01; v[8:7] = 2'b10; v[6:5] = 2'b00;
                v[2:0] = 3'b000; m |= 19'h007E7;
            end
            P_BEQ: begin
                v[B_PCWRITE] = z; v[B_RETIRE] = 1'b1; v[10:9] = 2'b10; v[8:7] = 2'b00;
                v[6:5] = 2'b00; v[2:0] = 3'b001; m |= 19'h007E7;
            end
            default: v[B_ILLEGAL] = 1'b1;
        endcase
        return {v, m};
    endfunction

    task automatic run_cycle(input int ph, input bit mr, input bit z, input bit rst);
        logic [18:0] obs, ev, em;
        rst_n = rst;
        mem_ready = mr;
        Zero = z;
        #1;
        {ev, em} = expect_of(ph, mr, z);
        obs = {MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Retire, Illegal, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
        cyc_in_instr++;
        if (Retire === 1'b1) begin
            ret_cnt++;
            ret_at = cyc_in_instr;
        end
        checks++;
        assert ((obs & em) === (ev & em)) else begin
            errors++;
            $error("FAIL %s#%0d cyc%0d observed=%05h expected=%05h", pname(ph), instr_no,
                   cyc_in_instr, obs & em, ev & em);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_phase(input int ph, input int w, input bit z, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i <= w; i++) begin
            if (i < w) begin
                run_cycle(ph, 1'b0, z, 1'b1);
                if (i + 1 == TO) begin
                    run_cycle(P_TRAP, 1'b0, z, 1'b1);
                    trapped = 1'b1;
                    return;
                end
            end else begin
                run_cycle(ph, 1'b1, z, 1'b1);
                return;
            end
        end
    endtask

    // Recover from TRAP: Illegal must hold while mem_ready toggles, then reset.
    task automatic trap_recover();
        for (int k = 0; k < 3; k++) run_cycle(P_TRAP, k[0], 1'b0, 1'b1);
        run_cycle(P_RESET, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input bit z, input int wf, input int wm);
        bit trapped;
        bit mem_op;
        int lat;
        instr_no++;
        op = o; funct3 = f3; funct7 = f7;
        cyc_in_instr = 0; ret_cnt = 0; ret_at = 0;
        mem_op = (o == LW) || (o == SW);
        wait_phase(P_FETCH, wf, z, trapped);
        if (!trapped) begin
            run_cycle(P_DECODE, 1'b1, z, 1'b1);
            case (o)
                LW: begin
                    run_cycle(P_MEMADR, 1'b1, z, 1'b1);
                    wait_phase(P_MEMREAD, wm, z, trapped);
                    if (!trapped) run_cycle(P_MEMWB, 1'b1, z, 1'b1);
                end
                SW: begin
                    run_cycle(P_MEMADR, 1'b1, z, 1'b1);
                    wait_phase(P_MEMWRITE, wm, z, trapped);
                end
                RT:  begin run_cycle(P_EXECR, 1'b1, z, 1'b1); run_cycle(P_ALUWB, 1'b1, z, 1'b1); end
                IT:  begin run_cycle(P_EXECI, 1'b1, z, 1'b1); run_cycle(P_ALUWB, 1'b1, z, 1'b1); end
                JAL: begin run_cycle(P_JAL, 1'b1, z, 1'b1);   run_cycle(P_ALUWB, 1'b1, z, 1'b1); end
                BEQ: run_cycle(P_BEQ, 1'b1, z, 1'b1);
                default: begin
                    run_cycle(P_TRAP, 1'b1, z, 1'b1);
                    trapped = 1'b1;
                end
            endcase
        end
        $display("instr %0d op=%b f3=%b f7=%b z=%b wf=%0d wm=%0d trap=%0d cycles=%0d",
                 instr_no, o, f3, f7, z, wf, wm, trapped, cyc_in_instr);
        if (trapped) begin
            trap_recover();
        end else begin
            lat = (o == BEQ) ? 3 : (o == LW) ? 5 : 4;
            lat = lat + wf + (mem_op ? wm : 0);
            checks++;
            assert ({ret_cnt, ret_at} === {32'sd1, lat}) else begin
                errors++;
                $error("FAIL latency#%0d observed retires=%0d at=%0d expected retires=1 at=%0d",
                       instr_no, ret_cnt, ret_at, lat);
            end
        end
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [2:0] f3s [6];
        ops = '{LW, SW, RT, IT, JAL, BEQ};
        f3s = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b100};
        op = LW; funct3 = 3'b000; funct7 = 1'b0; Zero = 1'b0; mem_ready = 1'b0; rst_n = 1'b0;
        run_cycle(P_RESET, 1'b0, 1'b0, 1'b0);
        run_cycle(P_RESET, 1'b1, 1'b0, 1'b0);

        instr(LW, 3'b010, 1'b0, 1'b0, 0, 0);
        instr(SW, 3'b010, 1'b0, 1'b0, 0, 3);
        instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
        instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
        instr(RT, 3'b111, 1'b0, 1'b0, 1, 0);
        instr(BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        instr(BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        instr(LW, 3'b010, 1'b0, 1'b0, 3, 3);
        instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
        instr(IT, 3'b110, 1'b0, 1'b0, 10, 0);
        instr(SW, 3'b010, 1'b0, 1'b0, 0, 9);

        // Reset while stalled in MEMREAD, then a clean instruction from FETCH
        instr_no++;
        op = LW; funct3 = 3'b010; funct7 = 1'b0; cyc_in_instr = 0;
        run_cycle(P_FETCH, 1'b1, 1'b0, 1'b1);
        run_cycle(P_DECODE, 1'b1, 1'b0, 1'b1);
        run_cycle(P_MEMADR, 1'b1, 1'b0, 1'b1);
        run_cycle(P_MEMREAD, 1'b0, 1'b0, 1'b1);
        run_cycle(P_RESET, 1'b1, 1'b0, 1'b0);
        $display("instr %0d op=%b reset during MEMREAD", instr_no, op);
        instr(RT, 3'b010, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] o;
            int sel;
            int wf, wm;
            sel = $urandom_range(0, 12);
            o = (sel == 12) ? (($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0000000)
                            : ops[sel / 2];
            wf = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            instr(o, f3s[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), wf, wm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I-subset core (lw, sw, R-type, I-type ALU, jal, beq).
- Sequences one instruction over 3–5 states through a single shared ALU and a single shared instruction/data memory port.
- Drives the existing alu via ALUControl and receives its Zero flag back.
- Includes a memory request/ready handshake, a stall timeout, and a sticky illegal-instruction trap.

Parameters:
- MEM_TIMEOUT, 0, maximum number of cycles to wait for mem_ready; 0 disables the timeout; 8-bit counter, legal range 0–255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- op  in  7  instruction opcode, taken from the IR.
- funct3  in  3  instruction bits [14:12].
- funct7  in  1  instruction bit 30.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current request this cycle.
- MemReq  out  1  memory request valid.
- MemWrite  out  1  memory write strobe.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- ImmSrc  out  2  immediate format select.
- ALUControl  out  3  ALU operation code.
- Retire  out  1  one-cycle pulse in the final state of each instruction.
- Illegal  out  1  sticky trap flag.

Behaviour:
- Reset: if rst_n is low at a clock edge, state goes to FETCH, the timeout counter clears, and Illegal clears. While rst_n is low, PCWrite, IRWrite, RegWrite, MemWrite, MemReq and Retire are forced to 0; all other outputs follow the FETCH decode. Reset wins over every other event, including reset in the middle of an instruction.
- Outputs are a Moore decode of the state. Exceptions:
  - PCWrite and IRWrite in FETCH are gated by mem_ready.
  - PCWrite in BEQ equals Zero.
  - ImmSrc is combinational from op: lw and I-type = 00, sw = 01, beq = 10, jal = 11, any other opcode = 00.
- States, outputs, and transitions (unlisted enables are 0; unlisted selects are don't-care):
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10. If mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay in FETCH.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (computes the branch/jump target).
    - op 0000011 or 0100011 → MEMADR.
    - op 0110011 → EXECR.
    - op 0010011 → EXECI.
    - op 1101111 → JAL.
    - op 1100011 → BEQ.
    - any other op → TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
  - MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Wait for mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Go to FETCH.
  - MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready; in the mem_ready cycle Retire=1, then go to FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, funct decode. Go to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, funct decode. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Go to ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUControl=001, ResultSrc=00, PCWrite=Zero, Retire=1. Go to FETCH.
  - TRAP: Illegal=1, all enables 0. Stays in TRAP until reset.
- ALUControl encoding: add = 000, sub = 001, and = 010, or = 011, slt = 101. Funct decode for EXECR/EXECI:
  - funct3 000: sub only if op[5]=1 and funct7=1, otherwise add. addi with funct7=1 is add.
  - funct3 010 → 101.
  - funct3 110 → 011.
  - funct3 111 → 010.
  - any other funct3 → 000.
- Timeout:
  - The counter increments on each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0. It clears on mem_ready or on a state change.
  - With MEM_TIMEOUT>0, when the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP.
  - If mem_ready is high in that same cycle, the handshake completes normally; mem_ready wins.
- Latency in cycles with zero memory wait: beq = 3, sw = 4, R-type = 4, I-type = 4, jal = 4, lw = 5. Each wait cycle adds 1.

Test Plan:
- lw (op=0000011), mem_ready=1 always → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; Retire pulses once.
- sw with mem_ready delayed 3 cycles in MEMWRITE → MemWrite=1 and MemReq=1 held for 4 cycles; RegWrite=0 throughout; ImmSrc=01; returns to FETCH.
- R-type funct3=000 with funct7=0 then funct7=1 → ALUControl 000 then 001 in EXECR. addi (op=0010011) with funct7=1 → ALUControl=000.
- beq with Zero=1 → PCWrite=1 in the BEQ state; with Zero=0 → PCWrite=0; ImmSrc=10 in both cases.
- jal → ImmSrc=11; PCWrite in JAL; next cycle ALUWB with RegWrite=1, ResultSrc=00.
- op=1111111 → TRAP; Illegal=1 held with mem_ready toggling. MEM_TIMEOUT=4 with mem_ready=0 in FETCH → TRAP after 4 cycles. rst_n=0 during MEMREAD → FETCH next edge, all enables 0.
